// File: rtl/fifo_vc_pkg.sv
// Shared defaults for the per-VC FIFO slice: word width, depth and flag thresholds.
// demux_vcid, fifo_vc and the VC arbiter all size themselves from these.
package fifo_vc_pkg;

  localparam int FIFO_DATA_WIDTH = 6;  // bits[5:4] class tag, bits[3:0] payload
  localparam int FIFO_ADDR_WIDTH = 2;
  localparam int FIFO_AF_THRESH  = 3;
  localparam int FIFO_AE_THRESH  = 1;

endpackage

// File: rtl/fifo_vc_mem_dp.sv
// DEPTH x DATA_WIDTH storage for fifo_vc: synchronous write port and a
// registered read port that holds its last value when not read.
module fifo_vc_mem_dp
  import fifo_vc_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end else begin
      mem[wr_addr] <= mem[wr_addr];
    end
  end

  // Read-before-write: a read and write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/fifo_vc.sv
// Per-virtual-channel FIFO: pointers, occupancy count, status flags and sticky error.
// almost_full is upstream backpressure; empty/almost_empty feed the VC arbiter.
module fifo_vc
  import fifo_vc_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_AF    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_AE    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic                  overflow;
  logic                  underflow;

  assign empty        = (count == CNT_ZERO);
  assign full         = (count == CNT_DEPTH);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

  // A pop frees a slot, so a push while full is still accepted alongside it.
  // Pop on empty is ignored without error when a push arrives (no bypass).
  always_comb begin
    do_pop    = 1'b0;
    do_push   = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    overflow  = push && !do_push;
    underflow = pop && empty && !push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= PTR_ZERO;
      rd_ptr    <= PTR_ZERO;
      count     <= CNT_ZERO;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_ptr    <= do_push ? (wr_ptr + PTR_ONE) : wr_ptr;
      rd_ptr    <= do_pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
      valid_out <= do_pop;
      error     <= error | overflow | underflow;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_vc_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (do_pop),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_vc.sv
// Self-checking bench for fifo_vc: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_vc;

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [5:0] data_in, data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, error;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [5:0] q[$];
  logic [5:0] m_dout;
  logic       m_valid;
  logic       m_err;
  logic [5:0] vals [4];

  always #5 clk = ~clk;

  fifo_vc dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .count        (count)
  );

  // Drive one cycle and advance the reference model; outputs are sampled 1 time unit later.
  task automatic cycle(input logic r, input logic pu, input logic po, input logic [5:0] d);
    bit can_pop;
    bit can_push;
    reset = r; push = pu; pop = po; data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = 6'h00; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      can_pop  = po && (q.size() > 0);
      can_push = pu && ((q.size() < 4) || can_pop);
      if (pu && !can_push) m_err = 1'b1;
      if (po && (q.size() == 0) && !pu) m_err = 1'b1;
      if (can_pop) begin
        m_dout = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (can_push) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 6'h00);
    cycle(1'b1, 1'b0, 1'b0, 6'h00);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", almost_empty); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if ({full, almost_full} !== 2'b00) begin errors++; $display("FAIL reset_full got %b exp 00", {full, almost_full}); end
    checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, vals[i]);
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (almost_empty !== (i == 0)) begin errors++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, almost_empty, i == 0); end
      checks++; if (almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, i >= 2); end
      checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 3); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 6'h00);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, valid_out); end
      checks++; if (data_out !== vals[i]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_out, vals[i]); end
    end
    cycle(1'b0, 1'b0, 1'b0, 6'h00);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_idle_valid got %b exp 0", valid_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    checks++; if (data_out !== vals[3]) begin errors++; $display("FAIL drain_hold got %h exp %h", data_out, vals[3]); end
  endtask

  task automatic test_overflow();
    test_fill();
    cycle(1'b0, 1'b1, 1'b0, 6'h3F);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", error); end
    test_drain();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", error); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_tail [4];
    exp_tail[0] = vals[1]; exp_tail[1] = vals[2]; exp_tail[2] = vals[3]; exp_tail[3] = 6'h05;
    cycle(1'b1, 1'b0, 1'b0, 6'h00);
    test_fill();
    cycle(1'b0, 1'b1, 1'b1, 6'h05);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_full_count got %0d exp 4", count); end
    checks++; if (data_out !== vals[0] || valid_out !== 1'b1) begin errors++; $display("FAIL pp_full_out got %h/%b exp %h/1", data_out, valid_out, vals[0]); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 6'h00);
      checks++; if (data_out !== exp_tail[i]) begin errors++; $display("FAIL pp_tail[%0d] got %h exp %h", i, data_out, exp_tail[i]); end
    end
    cycle(1'b0, 1'b1, 1'b1, 6'h2B);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pp_empty_count got %0d exp 1", count); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL pp_empty_valid got %b exp 0", valid_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL pp_empty_error got %b exp 0", error); end
    cycle(1'b0, 1'b0, 1'b1, 6'h00);
    checks++; if (data_out !== 6'h2B) begin errors++; $display("FAIL pp_empty_word got %h exp 2b", data_out); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 6'h21);
    cycle(1'b0, 1'b1, 1'b0, 6'h22);
    cycle(1'b1, 1'b1, 1'b0, 6'h23);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rstmid_error got %b exp 0", error); end
    cycle(1'b0, 1'b0, 1'b1, 6'h00);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL underflow_error got %b exp 1", error); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL underflow_valid got %b exp 0", valid_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", count); end
  endtask

  task automatic test_random();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 6'h00);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom()));
      n = q.size();
      checks++;
      if (count !== 3'(n) || empty !== (n == 0) || full !== (n == 4) ||
          almost_full !== (n >= 3) || almost_empty !== (n <= 1) ||
          valid_out !== m_valid || data_out !== m_dout || error !== m_err) begin
        errors++;
        $display("FAIL rand[%0d] got cnt=%0d e=%b f=%b af=%b ae=%b v=%b d=%h err=%b exp cnt=%0d v=%b d=%h err=%b",
                 i, count, empty, full, almost_full, almost_empty, valid_out, data_out, error,
                 n, m_valid, m_dout, m_err);
      end
    end
  endtask

  initial begin
    vals[0] = 6'h11; vals[1] = 6'h32; vals[2] = 6'h33; vals[3] = 6'h14;
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 6'h00;
    m_dout = 6'h00; m_valid = 1'b0; m_err = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
